// File: rtl/func_chk_pkg.sv
// Shared types and sizes for the func truth-table response checker.
package func_chk_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 4;

  // State names carry an S_ prefix so they cannot collide with the SETTLE parameter.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } chk_state_t;

endpackage

// File: rtl/func_response_checker.sv
// Walks {a,b,c,d} through all 16 indices, samples f after a settle delay and
// compares the captured truth table against a golden table.
module func_response_checker
  import func_chk_pkg::*;
#(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'hE8E8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail,
  output logic        first_fail_valid
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [4:0]       MAX_FAILS   = 5'(NUM_VECTORS);

  chk_state_t r_state;
  chk_state_t w_nextState;

  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_wait;
  logic [15:0]      r_captured;
  logic [4:0]       r_failCount;
  logic [3:0]       r_firstFail;
  logic             r_firstFailValid;
  logic             w_mismatch;

  assign w_mismatch = (f != EXPECTED[r_idx]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_nextState = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_wait == SETTLE_LAST) w_nextState = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_nextState = (r_idx == LAST_IDX) ? S_DONE : S_SETTLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Counters and result registers; start in IDLE/DONE wipes the previous run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx            <= '0;
      r_wait           <= '0;
      r_captured       <= '0;
      r_failCount      <= '0;
      r_firstFail      <= '0;
      r_firstFailValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_idx            <= '0;
            r_wait           <= '0;
            r_captured       <= '0;
            r_failCount      <= '0;
            r_firstFail      <= '0;
            r_firstFailValid <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_wait <= r_wait + 1'b1;
        end
        S_SAMPLE: begin
          r_captured[r_idx] <= f;
          if (w_mismatch) begin
            if (r_failCount != MAX_FAILS) r_failCount <= r_failCount + 1'b1;
            if (!r_firstFailValid) begin
              r_firstFail      <= r_idx;
              r_firstFailValid <= 1'b1;
            end
          end
          if (r_idx != LAST_IDX) begin
            r_idx  <= r_idx + 1'b1;
            r_wait <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // The DUT inputs come straight from the index register, never from f.
  assign {a, b, c, d}      = r_idx;
  assign busy              = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done              = (r_state == S_DONE);
  assign pass              = done && (r_failCount == 5'd0);
  assign captured          = r_captured;
  assign fail_count        = r_failCount;
  assign first_fail        = r_firstFail;
  assign first_fail_valid  = r_firstFailValid;

endmodule

// File: tb/tb_func_response_checker.sv
// Directed bench for func_response_checker: a behavioural func model with
// selectable faults, a table of full runs and hand-written corner sequences.
module tb_func_response_checker;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] expCaptured;
    logic [4:0]  expFailCount;
    logic [3:0]  expFirstFail;
    logic        expFirstFailValid;
    logic        expPass;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        f;
  logic        a, b, c, d;
  logic        busy, done, pass;
  logic [15:0] captured;
  logic [4:0]  failCount;
  logic [3:0]  firstFail;
  logic        firstFailValid;
  logic [2:0]  faultMode = 3'd0;

  int assertCount = 0;
  int errorCount  = 0;

  vec_t vecs [5];

  always #5 clk = ~clk;

  // Golden func is the majority of b, c and d (a is a don't-care), i.e. 16'hE8E8.
  function automatic logic modelF(input logic [2:0] mode, input logic [3:0] idx);
    logic good;
    good = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
    case (mode)
      3'd0:    modelF = good;
      3'd1:    modelF = 1'b0;
      3'd2:    modelF = good ^ (idx == 4'd9);
      3'd3:    modelF = 1'b1;
      3'd4:    modelF = ~good;
      default: modelF = good;
    endcase
  endfunction

  assign f = modelF(faultMode, {a, b, c, d});

  func_response_checker #(
    .SETTLE   (2),
    .EXPECTED (16'hE8E8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .f                (f),
    .a                (a),
    .b                (b),
    .c                (c),
    .d                (d),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .captured         (captured),
    .fail_count       (failCount),
    .first_fail       (firstFail),
    .first_fail_valid (firstFailValid)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulses start for one edge and counts edges until done is seen (bounded).
  task automatic applyStimulus(output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic checkResults(input string tag, input vec_t v);
    checkOutput({tag, " done"}, done, 1'b1);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " captured"}, captured, v.expCaptured);
    checkOutput({tag, " fail_count"}, failCount, v.expFailCount);
    checkOutput({tag, " first_fail_valid"}, firstFailValid, v.expFirstFailValid);
    if (v.expFirstFailValid) checkOutput({tag, " first_fail"}, firstFail, v.expFirstFail);
    checkOutput({tag, " pass"}, pass, v.expPass);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " abcd/busy/done/pass/ffv"},
                {a, b, c, d, busy, done, pass, firstFailValid}, 8'h00);
    checkOutput({tag, " captured"}, captured, 16'h0000);
    checkOutput({tag, " fail_count"}, failCount, 5'd0);
    checkOutput({tag, " first_fail"}, firstFail, 4'd0);
  endtask

  initial begin
    int cycles;
    int n;
    logic busyHeld;

    vecs[0] = '{3'd0, 16'hE8E8, 5'd0,  4'd0, 1'b0, 1'b1};
    vecs[1] = '{3'd1, 16'h0000, 5'd8,  4'd3, 1'b1, 1'b0};
    vecs[2] = '{3'd2, 16'hEAE8, 5'd1,  4'd9, 1'b1, 1'b0};
    vecs[3] = '{3'd3, 16'hFFFF, 5'd8,  4'd0, 1'b1, 1'b0};
    vecs[4] = '{3'd4, 16'h1717, 5'd16, 4'd0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    checkIdle("reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkIdle("idle no start");

    for (int i = 0; i < 5; i++) begin
      faultMode = vecs[i].mode;
      applyStimulus(cycles);
      checkOutput($sformatf("vec%0d run length", i), cycles, 48);
      checkResults($sformatf("vec%0d", i), vecs[i]);
    end

    // Vector sequence: each index held exactly 3 cycles with busy high.
    faultMode = 3'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 48; k++) begin
      logic [4:0] expSeq;
      if (k > 0) @(negedge clk);
      expSeq = {4'(k / 3), 1'b1};
      checkOutput($sformatf("abcd/busy cycle %0d", k), {a, b, c, d, busy}, expSeq);
    end
    @(negedge clk);
    checkOutput("seq done/busy", {done, busy}, 2'b10);

    // Reset in the middle of a failing run discards the partial results.
    faultMode = 3'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ({a, b, c, d} != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached idx 5", {a, b, c, d}, 4'd5);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkIdle("mid-run reset");
    @(negedge clk);
    checkIdle("after reset stays idle");
    faultMode = 3'd0;
    applyStimulus(cycles);
    checkOutput("post-reset run length", cycles, 48);
    checkResults("post-reset run", vecs[0]);

    // start held high: no restart mid-run, then restart from DONE.
    faultMode = 3'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cycles = 0;
    busyHeld = 1'b1;
    while (!done && cycles < 200) begin
      if (!busy) busyHeld = 1'b0;
      @(negedge clk);
      cycles++;
    end
    checkOutput("held-start run length", cycles, 48);
    checkOutput("held-start busy throughout", busyHeld, 1'b1);
    checkResults("held-start run1", vecs[2]);
    @(negedge clk);
    checkOutput("restart busy/done", {busy, done}, 2'b10);
    checkOutput("restart cleared captured", captured, 16'h0000);
    checkOutput("restart cleared fail_count", failCount, 5'd0);
    checkOutput("restart cleared ffv", firstFailValid, 1'b0);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("held-start run2 length", cycles, 48);
    checkResults("held-start run2", vecs[2]);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, errorCount);
    $finish;
  end

endmodule

// File: doc/func_response_checker.md
# func_response_checker

Self-checking response analyser for the four-input combinational `func` block. It walks the input vector {a,b,c,d} through all 16 combinations in ascending order and holds each vector for a programmable settle time. It samples `f`, assembles the captured 16-entry truth table, and compares it bit-by-bit against a golden table, reporting pass/fail, the mismatch count and the first failing index. It sits beside `func` on the lab board as the consumer of its output, replacing manual truth-table checking.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each vector is held before `f` is sampled; legal range is 1..15.
- `EXPECTED`, default 16'hE8E8: golden truth table; bit i is the expected `f` for index i = {a,b,c,d}, with a as the MSB.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level-sampled; begins a run when in IDLE or DONE.
- `f`  in  1  DUT output being checked.
- `a`, `b`, `c`, `d`  out  1 each  DUT inputs; {a,b,c,d} = current index.
- `busy`  out  1  high while a run is in progress (SETTLE or SAMPLE).
- `done`  out  1  high while in DONE.
- `pass`  out  1  valid when `done`=1; equals (`fail_count`==0).
- `captured`  out  16  sampled truth table; bit i is `f` observed at index i.
- `fail_count`  out  5  number of mismatching indices, 0..16.
- `first_fail`  out  4  lowest index that mismatched.
- `first_fail_valid`  out  1  high once any mismatch has been recorded.

## Operation
- States:
  - IDLE: all outputs at their reset values.
  - SETTLE: counting settle cycles for the current vector.
  - SAMPLE: one cycle in which `f` is captured and compared.
  - DONE: results held.
- IDLE/DONE → SETTLE on `start`=1. On the same edge:
  - idx←0, wait_cnt←0.
  - `captured`, `fail_count`, `first_fail` and `first_fail_valid` are cleared.
- SETTLE: wait_cnt increments each cycle. When wait_cnt==SETTLE-1, the next state is SAMPLE.
- SAMPLE: `captured[idx]`←`f`.
  - If `f`≠`EXPECTED[idx]`: `fail_count` increments. If `first_fail_valid`=0, then `first_fail`←idx and `first_fail_valid`←1.
  - If idx==15, the next state is DONE; otherwise idx increments, wait_cnt←0 and the next state is SETTLE.
- DONE: the state persists and all results hold until `start` or reset.
- `start` is ignored while `busy`=1.
- {a,b,c,d} is driven directly from the idx register, with no combinational path from `f`.
- `fail_count` never wraps; 16 is its maximum.

Reset (`reset_n`=0 at a clock edge):
- State goes to IDLE and idx to 0.
- All outputs go to 0: a, b, c, d, `busy`, `done`, `pass`, `captured`, `fail_count`, `first_fail`, `first_fail_valid`.
- Reset during a run aborts it; partial results are discarded.

## Timing
- Each vector is held SETTLE+1 cycles: SETTLE cycles in the SETTLE state plus 1 in SAMPLE.
- `f` is sampled at the end of the SAMPLE cycle, i.e. SETTLE+1 edges after the vector changed.
- A run lasts 16·(SETTLE+1) cycles from the `start` edge to the DONE entry edge. With SETTLE=2 that is 48 cycles.
- `busy` falls and `done` rises on the same edge.
- Results update on the SAMPLE edge and are visible the following cycle.
- `start` asserted on the edge that enters DONE is not acted on until the next cycle in DONE.
- If reset and start are both active on an edge, reset wins.

## Structure
- Package `func_chk_pkg` holds:
  - the state enum `chk_state_t` (IDLE, SETTLE, SAMPLE, DONE);
  - `NUM_VECTORS`=16 and `IDX_W`=4;
  - `CNT_W`=4 for the settle counter.
- Single module with no sub-modules. The settle counter and idx counter are small enough to live inline.

## Test plan
- Behavioural `func` model with truth table 16'hE8E8, `SETTLE`=2, pulse `start` → `done` after 48 cycles, `captured`=16'hE8E8, `fail_count`=0, `pass`=1, `first_fail_valid`=0.
- `f` tied to 0 → `captured`=16'h0000, `fail_count`=8, `first_fail`=3, `first_fail_valid`=1, `pass`=0.
- Model output inverted only at index 9 ({a,b,c,d}=1001) → `fail_count`=1, `first_fail`=9, `captured`=16'hEAE8.
- Monitor {a,b,c,d} during a run with `SETTLE`=2 → sequence 0000…1111 in order, each value held exactly 3 cycles, `busy`=1 throughout.
- `reset_n`=0 for one cycle while idx=5 → next cycle: state IDLE, all outputs 0. A subsequent `start` completes a full correct run.
- `start` held high for the whole run → no restart mid-run. On the cycle after DONE entry, the held `start` restarts the run and clears `fail_count`/`captured`; the second run's results match the first.
